ts_serial_deser: RTL

Serial-to-byte converter for MPEG-TS from the on-board demodulators. It selects the DVB/DTMB or ATSC serial interface, synchronises it into `clk`, and deserialises bits MSB-first into bytes. Packet framing is checked against sync byte 0x47 and 188-byte length. It sits directly upstream of the TS FIFO/USB proxy stage and supplies its `strt`/`dval`/`data` byte stream.

---
 rtl/ts_pkg.sv | 22 ++
 rtl/ts_sync2.sv | 24 ++
 rtl/ts_serial_deser.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ts_pkg.sv
// Shared constants and types for the serial MPEG-TS deserialiser.
package ts_pkg;

    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
    localparam int         TS_PKT_LEN   = 188;

    localparam logic [1:0] INSEL_DVB  = 2'b00;
    localparam logic [1:0] INSEL_DTMB = 2'b01;
    localparam logic [1:0] INSEL_ATSC = 2'b10;
    localparam logic [1:0] INSEL_NONE = 2'b11;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Error counters stick at full scale rather than wrapping back to a clean-looking zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ts_sync2.sv
// Two-flop synchroniser for one asynchronous serial input.
module ts_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/ts_serial_deser.sv
// Serial MPEG-TS to byte stream: source select, synchronisation, MSB-first
// deserialisation and packet framing checks (sync byte and packet length).
module ts_serial_deser
    import ts_pkg::*;
#(
    parameter int         PKT_LEN   = TS_PKT_LEN,
    parameter logic [7:0] SYNC_BYTE = TS_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  insel,
    input  logic        dvb_clock,
    input  logic        dvb_start,
    input  logic        dvb_valid,
    input  logic        dvb_data,
    input  logic        atsc_clock,
    input  logic        atsc_start,
    input  logic        atsc_valid,
    input  logic        atsc_data,
    output logic        dval,
    output logic        strt,
    output logic [7:0]  data,
    output logic [15:0] pkt_cnt,
    output logic [15:0] sync_err,
    output logic [15:0] len_err
);

    localparam logic [7:0] IDX_END  = 8'(PKT_LEN);
    localparam logic [7:0] IDX_LAST = 8'(PKT_LEN - 1);

    logic [7:0] raw;
    logic [7:0] syn;

    assign raw = {atsc_data, atsc_valid, atsc_start, atsc_clock,
                  dvb_data,  dvb_valid,  dvb_start,  dvb_clock};

    for (genvar i = 0; i < 8; i++) begin : g_sync
        ts_sync2 u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (raw[i]),
            .q     (syn[i])
        );
    end

    logic [1:0]  insel_q;
    logic [1:0]  insel_prev_q;
    logic        sclk_q;
    state_t      state_q;
    logic [7:0]  shift_q;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  byte_idx_q;
    logic        dval_q;
    logic        strt_q;
    logic [7:0]  data_q;
    logic [15:0] pkt_cnt_q;
    logic [15:0] sync_err_q;
    logic [15:0] len_err_q;

    logic [3:0] src;
    always_comb begin
        src = 4'b0000;
        case (insel_q)
            INSEL_DVB, INSEL_DTMB: src = syn[3:0];
            INSEL_ATSC:            src = syn[7:4];
            INSEL_NONE:            src = 4'b0000;
        endcase
    end

    // src = {data, valid, start, clock}; the edge is masked for the one cycle
    // the source changes, while sclk_q reloads from the new source.
    logic       insel_chg;
    logic       tick;
    logic       accept;
    logic [7:0] byte_d;

    assign insel_chg = (insel_q != insel_prev_q);
    assign tick      = src[0] & ~sclk_q & ~insel_chg;
    assign accept    = tick & src[2];
    assign byte_d    = {shift_q[6:0], src[3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            insel_q      <= INSEL_DVB;
            insel_prev_q <= INSEL_DVB;
            sclk_q       <= 1'b0;
            state_q      <= HUNT;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 4'd0;
            byte_idx_q   <= 8'd0;
            dval_q       <= 1'b0;
            strt_q       <= 1'b0;
            data_q       <= 8'h00;
            pkt_cnt_q    <= 16'h0000;
            sync_err_q   <= 16'h0000;
            len_err_q    <= 16'h0000;
        end else begin
            insel_q      <= insel;
            insel_prev_q <= insel_q;
            sclk_q       <= src[0];
            dval_q       <= 1'b0;
            strt_q       <= 1'b0;
            if (insel_chg) begin
                state_q    <= HUNT;
                bit_cnt_q  <= 4'd0;
                byte_idx_q <= 8'd0;
            end else if (accept) begin
                if (src[1]) begin
                    if (state_q == SHIFT && (byte_idx_q != IDX_END || bit_cnt_q != 4'd0))
                        len_err_q <= sat_inc(len_err_q);
                    state_q    <= SHIFT;
                    bit_cnt_q  <= 4'd1;
                    shift_q    <= {7'b0, src[3]};
                    byte_idx_q <= 8'd0;
                end else if (state_q == SHIFT) begin
                    if (byte_idx_q == IDX_END && bit_cnt_q == 4'd0) begin
                        len_err_q <= sat_inc(len_err_q);
                        state_q   <= HUNT;
                    end else begin
                        shift_q <= byte_d;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_q <= 4'd0;
                            if (byte_idx_q == 8'd0 && byte_d != SYNC_BYTE) begin
                                sync_err_q <= sat_inc(sync_err_q);
                                state_q    <= HUNT;
                            end else begin
                                dval_q     <= 1'b1;
                                strt_q     <= (byte_idx_q == 8'd0);
                                data_q     <= byte_d;
                                byte_idx_q <= byte_idx_q + 8'd1;
                                if (byte_idx_q == IDX_LAST)
                                    pkt_cnt_q <= pkt_cnt_q + 16'd1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign dval     = dval_q;
    assign strt     = strt_q;
    assign data     = data_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign sync_err = sync_err_q;
    assign len_err  = len_err_q;

endmodule
